dma_24b_32b_pack: RTL and testbench
===================================

DMA_24B_32B_PACK -- requirements
Module: dma_24b_32b_pack

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the per-frame written-word counter.
REQ-002 SHALL have port sys_clk, input, 1: rising-edge clock for all logic.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port dma_rst_i, input, 1: synchronous frame-start clear, active-high.
REQ-005 SHALL have port pix_de_i, input, 1: 24-bit pixel valid, one pixel per high cycle, contiguous per line.
REQ-006 SHALL have port pix_d_i, input, 24: pixel data.
REQ-007 SHALL have port wr_full_i, input, 1: downstream write FIFO full.
REQ-008 SHALL have port wr_en_o, output, 1: 32-bit word write strobe, registered.
REQ-009 SHALL have port wr_d_o, output, 32: packed word, registered, valid when wr_en_o=1.
REQ-010 SHALL have port wr_cnt_o, output, CNT_W: words written since the last dma_rst_i, saturating.
REQ-011 SHALL have port ovf_o, output, 1: sticky overflow flag.

Function
REQ-012 SHALL pack 4 pixels p0..p3 into 3 little-endian words: W0={p1[7:0],p0[23:0]}, W1={p2[15:0],p1[23:8]}, W2={p3[23:0],p2[23:16]}.
REQ-013 SHALL track phase PH0..PH3 = residue of 0/3/2/1 bytes; phase SHALL reset to PH0 at every line start.
REQ-014 On accepted pixel: PH0 -> store 3 bytes, no write, go PH1; PH1 -> write W0, keep p[23:8], go PH2; PH2 -> write W1, keep p[23:16], go PH3; PH3 -> write W2, go PH0.
REQ-015 Latency: wr_en_o/wr_d_o SHALL assert on the clock edge after the sys_clk edge that samples the completing pixel (1 cycle).
REQ-016 Line end: pix_de_i low with registered pix_de high and phase != PH0 -> next cycle SHALL emit one flush word: residue in the low bytes, zero-padded high bytes; phase -> PH0.
REQ-017 Line end in PH0 SHALL emit nothing.
REQ-018 Line start (pix_de_i rising) SHALL force phase PH0 and discard any residue before accepting the first pixel.
REQ-019 wr_en_o SHALL be a single-cycle pulse per word; wr_d_o SHALL be 0 when wr_en_o=0.
REQ-020 If wr_full_i=1 in the cycle a word is to be written, the word SHALL be dropped (wr_en_o stays 0), ovf_o SHALL set, and phase SHALL advance as if written.
REQ-021 wr_cnt_o SHALL increment by 1 per asserted wr_en_o, saturating at all-ones without wrap.
REQ-022 dma_rst_i=1 SHALL take priority over all events: phase -> PH0, residue cleared, wr_en_o=0, wr_d_o=0, wr_cnt_o=0, ovf_o=0 on the next edge. Pixels in that cycle SHALL be discarded.
REQ-023 ovf_o SHALL clear only by dma_rst_i or rst_n.
REQ-024 Simultaneous flush condition and wr_full_i=1 SHALL drop the flush word and set ovf_o.

Reset
REQ-025 rst_n low SHALL immediately clear wr_en_o=0, wr_d_o=0, wr_cnt_o=0, ovf_o=0, phase PH0, residue 0, and registered pix_de 0.
REQ-026 rst_n deassertion mid-line SHALL leave the block waiting for the next pix_de_i rising edge.
REQ-027 Any partial residue SHALL be discarded by reset, with no flush word emitted.

Verification
REQ-028 Line of 4 pixels 0x030201,0x060504,0x090807,0x0C0B0A -> words 0x04030201, 0x08070605, 0x0C0B0A09; each 1 cycle after its completing pixel; wr_cnt_o=3.
REQ-029 Line of 5 pixels (above plus 0x0F0E0D) -> 3 words, then 1 cycle after de falls flush 0x000F0E0D; wr_cnt_o=4.
REQ-030 Two 1-pixel lines 0xAABBCC, 0x112233 -> flushes 0x00AABBCC then 0x00112233; no cross-line merging.
REQ-031 wr_full_i=1 during 2nd word of a 4-pixel line -> words 1 and 3 written, ovf_o=1 sticky, wr_cnt_o=2; dma_rst_i pulse -> ovf_o=0, wr_cnt_o=0.
REQ-032 rst_n asserted after 2 pixels -> outputs 0 immediately, no flush; next 4-pixel line packs from PH0 correctly.
REQ-033 CNT_W=4 with 17 words -> wr_cnt_o saturates at 0xF.

Source files
------------

// File: rtl/dma_24b_32b_pack.sv
// rtl/dma_24b_32b_pack.sv - packs a stream of 24-bit pixels into little-endian 32-bit DMA words
module dma_24b_32b_pack #(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             dma_rst_i,
  input  logic             pix_de_i,
  input  logic [23:0]      pix_d_i,
  input  logic             wr_full_i,
  output logic             wr_en_o,
  output logic [31:0]      wr_d_o,
  output logic [CNT_W-1:0] wr_cnt_o,
  output logic             ovf_o
);

  // Phase names the number of residue bytes held: PH0=0, PH1=3, PH2=2, PH3=1.
  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

  phase_e             phase_q, phase_d, phase_eff;
  logic [23:0]        res_q, res_d;
  logic               pix_de_q, pix_de_d;
  logic               wait_q, wait_d;
  logic               wr_en_q, wr_en_d;
  logic [31:0]        wr_d_q, wr_d_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic               de_eff;
  logic               line_start;
  logic               line_end;
  logic               word_vld;
  logic [31:0]        word;

  // After reset the block ignores the rest of an in-flight line until pix_de_i drops.
  assign de_eff     = pix_de_i & ~wait_q;
  assign line_start = de_eff & ~pix_de_q;
  assign line_end   = ~de_eff & pix_de_q & (phase_q != PH0);
  assign phase_eff  = line_start ? PH0 : phase_q;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PH0;
      res_q    <= '0;
      pix_de_q <= 1'b0;
      wait_q   <= 1'b1;
      wr_en_q  <= 1'b0;
      wr_d_q   <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      res_q    <= res_d;
      pix_de_q <= pix_de_d;
      wait_q   <= wait_d;
      wr_en_q  <= wr_en_d;
      wr_d_q   <= wr_d_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    if (dma_rst_i) begin
      phase_d = PH0;
    end else if (de_eff) begin
      case (phase_eff)
        PH0:     phase_d = PH1;
        PH1:     phase_d = PH2;
        PH2:     phase_d = PH3;
        default: phase_d = PH0;
      endcase
    end else if (line_end) begin
      phase_d = PH0;
    end
  end

  always_comb begin
    res_d    = res_q;
    word     = '0;
    word_vld = 1'b0;
    if (de_eff) begin
      case (phase_eff)
        PH0: begin
          res_d = pix_d_i;
        end
        PH1: begin
          word     = {pix_d_i[7:0], res_q};
          word_vld = 1'b1;
          res_d    = {8'h00, pix_d_i[23:8]};
        end
        PH2: begin
          word     = {pix_d_i[15:0], res_q[15:0]};
          word_vld = 1'b1;
          res_d    = {16'h0000, pix_d_i[23:16]};
        end
        default: begin
          word     = {pix_d_i, res_q[7:0]};
          word_vld = 1'b1;
          res_d    = '0;
        end
      endcase
    end else if (line_end) begin
      case (phase_q)
        PH1:     word = {8'h00, res_q};
        PH2:     word = {16'h0000, res_q[15:0]};
        PH3:     word = {24'h000000, res_q[7:0]};
        default: word = '0;
      endcase
      word_vld = 1'b1;
      res_d    = '0;
    end

    // A word that meets a full FIFO is lost, but the packing keeps advancing.
    wr_en_d  = word_vld & ~wr_full_i;
    wr_d_d   = wr_en_d ? word : '0;
    ovf_d    = ovf_q | (word_vld & wr_full_i);
    cnt_d    = (wr_en_d && (cnt_q != '1)) ? cnt_q + {{(CNT_W-1){1'b0}}, 1'b1} : cnt_q;
    pix_de_d = de_eff;
    wait_d   = wait_q & pix_de_i;

    if (dma_rst_i) begin
      res_d    = '0;
      wr_en_d  = 1'b0;
      wr_d_d   = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      pix_de_d = 1'b0;
    end
  end

  assign wr_en_o  = wr_en_q;
  assign wr_d_o   = wr_d_q;
  assign wr_cnt_o = cnt_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_dma_24b_32b_pack.sv
// tb/tb_dma_24b_32b_pack.sv - directed self-checking bench for dma_24b_32b_pack
module tb_dma_24b_32b_pack;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dma_rst_i = 1'b0;
  logic        pix_de_i = 1'b0;
  logic [23:0] pix_d_i = '0;
  logic        wr_full_i = 1'b0;

  logic        wr_en_o;
  logic [31:0] wr_d_o;
  logic [15:0] wr_cnt_o;
  logic        ovf_o;

  logic        s_wr_en_o;
  logic [31:0] s_wr_d_o;
  logic [3:0]  s_wr_cnt_o;
  logic        s_ovf_o;

  dma_24b_32b_pack #(.CNT_W(16)) u_dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .dma_rst_i(dma_rst_i),
    .pix_de_i(pix_de_i), .pix_d_i(pix_d_i), .wr_full_i(wr_full_i),
    .wr_en_o(wr_en_o), .wr_d_o(wr_d_o), .wr_cnt_o(wr_cnt_o), .ovf_o(ovf_o)
  );

  dma_24b_32b_pack #(.CNT_W(4)) u_dut_sat (
    .sys_clk(sys_clk), .rst_n(rst_n), .dma_rst_i(dma_rst_i),
    .pix_de_i(pix_de_i), .pix_d_i(pix_d_i), .wr_full_i(wr_full_i),
    .wr_en_o(s_wr_en_o), .wr_d_o(s_wr_d_o), .wr_cnt_o(s_wr_cnt_o), .ovf_o(s_ovf_o)
  );

  always #5 sys_clk = ~sys_clk;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] got_q[$];
  int          got_c[$];
  logic [23:0] px[0:7];
  int          pc[0:7];
  int          fall_c;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge sys_clk) begin
    if (rst_n) begin
      if (wr_en_o) begin
        got_q.push_back(wr_d_o);
        got_c.push_back(cyc);
      end else begin
        check("idle_zero", wr_d_o, 32'h0);
      end
    end
  end

  function automatic logic [31:0] gw(input int i);
    return (i < got_q.size()) ? got_q[i] : 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] gc(input int i);
    return (i < got_c.size()) ? got_c[i] : 32'hFFFFFFFF;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_q();
    got_q.delete();
    got_c.delete();
  endtask

  task automatic send(input int n, input int full_idx, input bit full_fall);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
      pix_de_i  = 1'b1;
      pix_d_i   = px[i];
      wr_full_i = (i == full_idx);
      pc[i]     = cyc;
    end
    @(posedge sys_clk); #1;
    pix_de_i  = 1'b0;
    pix_d_i   = '0;
    wr_full_i = full_fall;
    fall_c    = cyc;
    @(posedge sys_clk); #1;
    wr_full_i = 1'b0;
  endtask

  task automatic dma_clear();
    @(posedge sys_clk); #1;
    dma_rst_i = 1'b1;
    @(posedge sys_clk); #1;
    dma_rst_i = 1'b0;
  endtask

  task automatic load_base();
    px[0] = 24'h030201; px[1] = 24'h060504; px[2] = 24'h090807;
    px[3] = 24'h0C0B0A; px[4] = 24'h0F0E0D;
  endtask

  initial begin
    load_base();
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_en", {31'b0, wr_en_o}, 32'h0);
    check("rst_d", wr_d_o, 32'h0);
    check("rst_cnt", {16'b0, wr_cnt_o}, 32'h0);
    check("rst_ovf", {31'b0, ovf_o}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // four-pixel line, exact multiple of three words
    clear_q();
    send(4, -1, 1'b0);
    idle(3);
    check("l4_n", got_q.size(), 3);
    check("l4_w0", gw(0), 32'h04030201);
    check("l4_w1", gw(1), 32'h08070605);
    check("l4_w2", gw(2), 32'h0C0B0A09);
    check("l4_lat0", gc(0), pc[1] + 1);
    check("l4_lat2", gc(2), pc[3] + 1);
    check("l4_cnt", {16'b0, wr_cnt_o}, 32'd3);

    // five-pixel line leaves one byte triple to flush
    dma_clear();
    clear_q();
    send(5, -1, 1'b0);
    idle(3);
    check("l5_n", got_q.size(), 4);
    check("l5_w2", gw(2), 32'h0C0B0A09);
    check("l5_flush", gw(3), 32'h000F0E0D);
    check("l5_flat", gc(3), fall_c + 1);
    check("l5_cnt", {16'b0, wr_cnt_o}, 32'd4);

    // back-to-back single-pixel lines must not merge
    dma_clear();
    clear_q();
    px[0] = 24'hAABBCC;
    send(1, -1, 1'b0);
    px[0] = 24'h112233;
    send(1, -1, 1'b0);
    idle(3);
    load_base();
    check("l1_n", got_q.size(), 2);
    check("l1_a", gw(0), 32'h00AABBCC);
    check("l1_b", gw(1), 32'h00112233);
    check("l1_cnt", {16'b0, wr_cnt_o}, 32'd2);

    // FIFO full on the second word
    dma_clear();
    clear_q();
    send(4, 2, 1'b0);
    idle(3);
    check("full_n", got_q.size(), 2);
    check("full_w0", gw(0), 32'h04030201);
    check("full_w2", gw(1), 32'h0C0B0A09);
    check("full_ovf", {31'b0, ovf_o}, 32'h1);
    check("full_cnt", {16'b0, wr_cnt_o}, 32'd2);
    idle(4);
    check("ovf_sticky", {31'b0, ovf_o}, 32'h1);
    dma_clear();
    check("dma_ovf", {31'b0, ovf_o}, 32'h0);
    check("dma_cnt", {16'b0, wr_cnt_o}, 32'h0);

    // flush that collides with a full FIFO is dropped
    clear_q();
    send(1, -1, 1'b1);
    idle(3);
    check("ffl_n", got_q.size(), 0);
    check("ffl_ovf", {31'b0, ovf_o}, 32'h1);
    dma_clear();

    // async reset mid-line, then de still high across release
    clear_q();
    for (int i = 0; i < 2; i++) begin
      @(posedge sys_clk); #1;
      pix_de_i = 1'b1;
      pix_d_i  = px[i];
    end
    @(posedge sys_clk); #2;
    pix_d_i = px[2];
    check("pre_rst_en", {31'b0, wr_en_o}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst_en", {31'b0, wr_en_o}, 32'h0);
    check("arst_d", wr_d_o, 32'h0);
    check("arst_cnt", {16'b0, wr_cnt_o}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(3);
    pix_de_i = 1'b0;
    pix_d_i  = '0;
    idle(3);
    check("arst_noflush", got_q.size(), 0);
    send(4, -1, 1'b0);
    idle(3);
    check("post_n", got_q.size(), 3);
    check("post_w0", gw(0), 32'h04030201);
    check("post_w1", gw(1), 32'h08070605);
    check("post_w2", gw(2), 32'h0C0B0A09);
    check("post_cnt", {16'b0, wr_cnt_o}, 32'd3);

    // 17 words into a 4-bit counter
    dma_clear();
    for (int k = 0; k < 5; k++) begin
      send(4, -1, 1'b0);
    end
    send(2, -1, 1'b0);
    idle(3);
    check("sat_cnt", {28'b0, s_wr_cnt_o}, 32'hF);
    check("wide_cnt", {16'b0, wr_cnt_o}, 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
